// File: rtl/raster_stream_src.sv
// raster_stream_src: reads an IH x IW frame in raster order from a
// synchronous-read memory and emits it as a valid/data/vsync pixel stream.
// Horizontal and vertical blanking are inserted between lines and frames.
// Optional test-pattern generator: define RASTER_SRC_TPG_EN to add tpg_sel.
module raster_stream_src #(
  parameter int DW     = 14,
  parameter int IH     = 512,
  parameter int IW     = 640,
  parameter int HBLANK = 16,
  parameter int VBLANK = 64,
  parameter int AW     = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cont,
`ifdef RASTER_SRC_TPG_EN
  input  logic          tpg_sel,
`endif
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          vsync_out,
  output logic          busy,
  output logic          frame_done
);

  localparam int XW = $clog2(IW + 1);
  localparam int YW = $clog2(IH + 1);
  localparam int CW = 16;

  typedef enum logic [1:0] {IDLE, ACT, HBLK, VBLK} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            tpg_q, tpg_d;
  logic            rd_en_q, rd_en_d;
  logic            busy_q, busy_d;
  // stage 1 of the output pipe (memory read in flight)
  logic            s1_valid_q, s1_valid_d;
  logic            s1_vsync_q, s1_vsync_d;
  logic            s1_last_q, s1_last_d;
  logic            s1_tpg_q, s1_tpg_d;
  logic [DW-1:0]   s1_pix_q, s1_pix_d;
  // stage 2 (output registers)
  logic [DW-1:0]   dout_q, dout_d;
  logic            dout_valid_q, dout_valid_d;
  logic            vsync_q, vsync_d;
  logic            frame_done_q, frame_done_d;
  logic            tpg_in;

`ifdef RASTER_SRC_TPG_EN
  assign tpg_in = tpg_sel;
`else
  assign tpg_in = 1'b0;
`endif

  // Next-state logic: raster walk, blanking counters and the delay pipe
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    tpg_d   = tpg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACT;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          tpg_d   = tpg_in;
        end
      end
      ACT: begin
        // address only advances inside the frame, so it never exceeds IH*IW-1
        if (x_q == XW'(IW - 1)) begin
          state_d = HBLK;
          cnt_d   = '0;
        end else begin
          x_d    = x_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      HBLK: begin
        if (cnt_q == CW'(HBLANK - 1)) begin
          if (y_q != YW'(IH - 1)) begin
            state_d = ACT;
            x_d     = '0;
            y_d     = y_q + 1'b1;
            addr_d  = addr_q + 1'b1;
          end else begin
            state_d = VBLK;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      VBLK: begin
        // cont only matters on the last blanking cycle
        if (cnt_q == CW'(VBLANK - 1)) begin
          if (cont) begin
            state_d = ACT;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
            tpg_d   = tpg_in;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_en_d = (state_d == ACT) && !tpg_d;
    busy_d  = (state_d != IDLE);

    // stage 1 captures the pixel issued this cycle; the last HBLK of a
    // frame is vertical blanking, so it does not hold vsync
    s1_valid_d = (state_q == ACT);
    s1_vsync_d = (state_q == ACT) || ((state_q == HBLK) && (y_q != YW'(IH - 1)));
    s1_last_d  = (state_q == ACT) && (x_q == XW'(IW - 1)) && (y_q == YW'(IH - 1));
    s1_tpg_d   = tpg_q;
    s1_pix_d   = DW'(x_q) + DW'(y_q);

    // stage 2: memory data has arrived; dout holds between pixels
    dout_valid_d = s1_valid_q;
    vsync_d      = s1_vsync_q;
    frame_done_d = s1_last_q;
    dout_d       = dout_q;
    if (s1_valid_q) dout_d = s1_tpg_q ? s1_pix_q : rd_data;
  end

  // State, counters and registered outputs with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      tpg_q        <= 1'b0;
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_vsync_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_tpg_q     <= 1'b0;
      s1_pix_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      vsync_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      tpg_q        <= tpg_d;
      rd_en_q      <= rd_en_d;
      busy_q       <= busy_d;
      s1_valid_q   <= s1_valid_d;
      s1_vsync_q   <= s1_vsync_d;
      s1_last_q    <= s1_last_d;
      s1_tpg_q     <= s1_tpg_d;
      s1_pix_q     <= s1_pix_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      vsync_q      <= vsync_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = addr_q;
  assign busy       = busy_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign vsync_out  = vsync_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_raster_stream_src.sv
// Bench for raster_stream_src: small 4x3 frame, memory returns addr+100.
// Every cycle is compared against a frame-timing model computed from the
// frame start cycle with plain arithmetic.
module tb_raster_stream_src;
  localparam int DW = 14, IH = 3, IW = 4, HB = 2, VB = 5, AW = 19;
  localparam int L    = IW + HB;       // cycles per line incl. blanking
  localparam int SPAN = IH * L - HB;   // first to last rd_en of a frame
  localparam int P    = SPAN + HB + VB; // frame period with cont=1

  logic          clk = 1'b0;
  logic          rst, start, cont;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] dout;
  logic          dout_valid, vsync_out, busy, frame_done;
`ifdef RASTER_SRC_TPG_EN
  logic          tpg_sel = 1'b0;
`endif

  raster_stream_src #(.DW(DW), .IH(IH), .IW(IW), .HBLANK(HB), .VBLANK(VB), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont),
`ifdef RASTER_SRC_TPG_EN
    .tpg_sel(tpg_sel),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .dout(dout),
    .dout_valid(dout_valid), .vsync_out(vsync_out), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // synchronous-read memory: data = address + 100, one cycle after rd_en
  always @(posedge clk) if (rd_en) rd_data <= DW'(rd_addr + 100);

  int tests = 0, fails = 0;
  int cyc = 0;
  int s = 0, nf = 0;
  bit tpg_m = 1'b0;
  logic [DW-1:0] exp_dout = '0;
  int rd_cnt = 0, fd_cnt = 0;

  typedef struct {
    int dly; int frames; bit glitch; bit tpg; int exp_rd; int exp_fd;
  } vec_t;
  vec_t vecs[$];

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // model: is a pixel issued in cycle c, and which one
  function automatic bit m_pix(input int c, output int x, output int y);
    int r, t;
    x = 0; y = 0;
    r = c - s;
    if (r < 0 || r >= nf * P) return 1'b0;
    t = r % P;
    if (t >= SPAN || (t % L) >= IW) return 1'b0;
    x = t % L;
    y = t / L;
    return 1'b1;
  endfunction

  function automatic bit m_vs(input int c);
    int r;
    r = c - s;
    return (r >= 0) && (r < nf * P) && ((r % P) < SPAN);
  endfunction

  task automatic check_cycle();
    int x, y, x2, y2, r;
    bit a, a2, e_rd, e_busy, e_fd;
    a  = m_pix(cyc, x, y);
    a2 = m_pix(cyc - 2, x2, y2);
    r  = cyc - s;
    e_busy = (r >= 0) && (r < nf * P);
    e_rd   = a && !tpg_m;
    e_fd   = a2 && (x2 == IW - 1) && (y2 == IH - 1);
    if (a2) exp_dout = tpg_m ? DW'(x2 + y2) : DW'(y2 * IW + x2 + 100);
    cmp($sformatf("cyc%0d rd_en/valid/vsync/busy/done/dout", cyc),
        64'({rd_en, dout_valid, vsync_out, busy, frame_done, dout}),
        64'({e_rd, a2, m_vs(cyc - 2), e_busy, e_fd, exp_dout}));
    if (e_rd) cmp($sformatf("cyc%0d rd_addr", cyc), 64'(rd_addr), 64'(y * IW + x));
    if (rd_en) rd_cnt++;
    if (frame_done) fd_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; start = 1'b0; cont = 1'b0; nf = 0; exp_dout = '0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic run_scn(input int dly, input int frames, input bit glitch, input bit tpg,
                         input int exp_rd, input int exp_fd);
    int r;
    repeat (dly) begin cont = 1'($urandom); tick(); end
    rd_cnt = 0; fd_cnt = 0;
    tpg_m = tpg;
`ifdef RASTER_SRC_TPG_EN
    tpg_sel = tpg;
`endif
    start = 1'b1; s = cyc + 1; nf = frames;
    tick();
    start = 1'b0;
    repeat (frames * P + 4) begin
      r = cyc - s;
      // cont is random except on the cycle where it is sampled
      if (r % P == P - 1) cont = (r / P < frames - 1);
      else cont = 1'($urandom);
      start = glitch && (r < frames * P) && ($urandom_range(0, 4) == 0);
      tick();
    end
    start = 1'b0;
    cmp($sformatf("rd_en count (%0d frames)", frames), 64'(rd_cnt), 64'(exp_rd));
    cmp($sformatf("frame_done count (%0d frames)", frames), 64'(fd_cnt), 64'(exp_fd));
    $display("[TB] scenario dly=%0d frames=%0d glitch=%0d tpg=%0d rd_en=%0d frame_done=%0d",
             dly, frames, glitch, tpg, rd_cnt, fd_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int fr, n;
    rst = 1'b0; start = 1'b0; cont = 1'b0;
    #1 rst = 1'b1;
    // reset, then 20 idle cycles with all outputs low
    do_reset(3);
    repeat (20) tick();
    cmp("idle busy", 64'(busy), 64'(0));

    vecs.push_back('{dly: 2, frames: 1, glitch: 1'b0, tpg: 1'b0, exp_rd: 12, exp_fd: 1});
    vecs.push_back('{dly: 0, frames: 1, glitch: 1'b1, tpg: 1'b0, exp_rd: 12, exp_fd: 1});
    vecs.push_back('{dly: 5, frames: 2, glitch: 1'b0, tpg: 1'b0, exp_rd: 24, exp_fd: 2});
    vecs.push_back('{dly: 1, frames: 3, glitch: 1'b1, tpg: 1'b0, exp_rd: 36, exp_fd: 3});
`ifdef RASTER_SRC_TPG_EN
    vecs.push_back('{dly: 3, frames: 2, glitch: 1'b1, tpg: 1'b1, exp_rd: 0, exp_fd: 2});
`endif
    foreach (vecs[i])
      run_scn(vecs[i].dly, vecs[i].frames, vecs[i].glitch, vecs[i].tpg,
              vecs[i].exp_rd, vecs[i].exp_fd);

    // randomized runs
    for (int i = 0; i < 4; i++) begin
      fr = $urandom_range(1, 2);
      run_scn($urandom_range(0, 9), fr, 1'($urandom), 1'b0, 12 * fr, fr);
    end

    // asynchronous reset in the middle of line 1, pixel 2
    start = 1'b1; s = cyc + 1; nf = 1; tpg_m = 1'b0;
    tick();
    start = 1'b0;
    n = 0;
    while (cyc < s + L + 2 && n < 100) begin tick(); n++; end
    cmp("mid-line rd_addr before reset", 64'(rd_addr), 64'(IW + 2));
    #2 rst = 1'b1;
    #1;
    cmp("async reset outputs",
        64'({rd_en, rd_addr, dout, dout_valid, vsync_out, busy, frame_done}), 64'(0));
    $display("[TB] async reset mid-line at cyc=%0d", cyc);
    nf = 0; exp_dout = '0;
    tick();
    tick();
    rst = 1'b0;
    run_scn(1, 1, 1'b0, 1'b0, 12, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
